// File: rtl/kf_matmul_arbiter.sv
// Round-robin arbiter/sequencer for the shared Kalman-filter matrix-multiply engine.
// Grants one requester, issues the engine start, waits for completion or watchdog expiry.
module kf_matmul_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CFG_W = 16,
  parameter int unsigned TO_W  = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CFG_W-1:0] req_cfg,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   mm_start,
  output logic [CFG_W-1:0]       mm_cfg,
  input  logic                   mm_done,
  output logic                   err_timeout,
  input  logic                   err_clr,
  output logic                   busy
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  // Watchdog value at the edge that would take it to its all-ones limit.
  localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] win;
  logic [TO_W-1:0]  wd;
  logic [CFG_W-1:0] cfg_arr [N_REQ];
  logic             wd_expire;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cfg_arr[i] = req_cfg[i*CFG_W +: CFG_W];
    end
  end

  // Scan offsets from farthest to nearest so the nearest requester after ptr wins.
  always_comb begin
    win = ptr;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (req[(32'(ptr) + N_REQ - k) % N_REQ]) begin
        win = IDX_W'((32'(ptr) + N_REQ - k) % N_REQ);
      end
    end
  end

  assign wd_expire = (wd == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= IDX_W'(N_REQ - 1);
      owner       <= '0;
      wd          <= '0;
      grant       <= '0;
      done        <= '0;
      mm_start    <= 1'b0;
      mm_cfg      <= '0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (err_clr) begin
        err_timeout <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= ISSUE;
            owner    <= win;
            grant    <= N_REQ'(1) << win;
            mm_cfg   <= cfg_arr[win];
            mm_start <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ISSUE: begin
          mm_start <= 1'b0;
          wd       <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wd <= wd + 1'b1;
          if (mm_done || wd_expire) begin
            done  <= N_REQ'(1) << owner;
            grant <= '0;
            state <= RELEASE;
            // A completion on the expiry edge wins; the set overrides a same-cycle clear.
            if (!mm_done) begin
              err_timeout <= 1'b1;
            end
          end
        end
        RELEASE: begin
          done  <= '0;
          ptr   <= owner;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kf_matmul_arbiter.sv
// Self-checking bench for kf_matmul_arbiter: job-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_kf_matmul_arbiter;

  localparam int N    = 4;
  localparam int CW   = 16;
  localparam int TOW  = 4;
  localparam int MAXW = (1 << TOW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req;
  logic [N*CW-1:0] req_cfg;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            mm_start;
  logic [CW-1:0]   mm_cfg;
  logic            mm_done;
  logic            err_timeout;
  logic            err_clr;
  logic            busy;

  kf_matmul_arbiter #(.N_REQ(N), .CFG_W(CW), .TO_W(TOW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_cfg(req_cfg), .grant(grant),
    .done(done), .mm_start(mm_start), .mm_cfg(mm_cfg), .mm_done(mm_done),
    .err_timeout(err_timeout), .err_clr(err_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: one job at a time, tracked by phase and count of WAIT edges.
  int           ph, age, m_owner, m_last;
  logic [N-1:0] e_grant, e_done;
  logic         e_start, e_busy, e_err;
  logic [CW-1:0] e_cfg;

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (r[idx]) return idx;
    end
    return last;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      ph <= 0; age <= 0; m_owner <= 0; m_last <= N - 1;
      e_grant <= '0; e_done <= '0; e_start <= 1'b0; e_busy <= 1'b0;
      e_err <= 1'b0; e_cfg <= '0;
    end else begin
      e_done  <= '0;
      e_start <= 1'b0;
      if (err_clr) e_err <= 1'b0;
      if (ph == 0) begin
        if (req != '0) begin
          w = pick(req, m_last);
          ph <= 1; m_owner <= w;
          e_grant <= N'(1 << w);
          e_cfg <= req_cfg[w*CW +: CW];
          e_start <= 1'b1; e_busy <= 1'b1;
        end
      end else if (ph == 1) begin
        ph <= 2; age <= 0;
      end else if (ph == 2) begin
        if (mm_done || (age + 1 == MAXW)) begin
          e_done <= N'(1 << m_owner);
          e_grant <= '0;
          ph <= 3;
          if (!mm_done) e_err <= 1'b1;
        end else begin
          age <= age + 1;
        end
      end else begin
        ph <= 0; e_busy <= 1'b0; m_last <= m_owner;
      end
    end
  end

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;
  chk_t chk_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  always @(negedge clk) begin
    chk_t c;
    n_tests++;
    if ({grant, done, mm_start, mm_cfg, busy, err_timeout} !==
        {e_grant, e_done, e_start, e_cfg, e_busy, e_err}) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t actual grant=%b done=%b start=%b cfg=%h busy=%b err=%b required grant=%b done=%b start=%b cfg=%h busy=%b err=%b",
               $time, grant, done, mm_start, mm_cfg, busy, err_timeout,
               e_grant, e_done, e_start, e_cfg, e_busy, e_err);
    end
    n_tests++;
    if (!$onehot0(grant)) begin
      n_fail++;
      $display("FAIL grant_onehot t=%0t actual %b required at most one bit", $time, grant);
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      n_tests++;
      if (c.act !== c.exp) begin
        n_fail++;
        $display("FAIL %s actual %0h required %0h", c.name, c.act, c.exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    chk_t c;
    c.name = nm; c.act = a; c.exp = e;
    chk_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic wait_start(output int w);
    w = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mm_start === 1'b1) begin
        w = idx_of(grant);
        return;
      end
    end
    chk("start_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic pulse_done(input int d);
    repeat (d) tick();
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int w;
    int n;
    int ord [5] = '{0, 1, 2, 3, 0};
    req = '0; req_cfg = '0; mm_done = 1'b0; err_clr = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cfg", 32'(mm_cfg), 32'd0);
    rst_n = 1'b1;

    // Single job, engine answers 5 cycles after start
    req = 4'b0001; req_cfg = 64'h0000_0000_0000_00A5;
    wait_start(w);
    chk("t1_grant", 32'(grant), 32'b0001);
    chk("t1_cfg", 32'(mm_cfg), 32'h00A5);
    chk("t1_busy", 32'(busy), 32'd1);
    req = '0;
    pulse_done(5);
    chk("t1_done", 32'(done), 32'b0001);
    tick(); tick();
    chk("t1_busy_low", 32'(busy), 32'd0);

    // All requesters held: rotation 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_start(w);
      chk("t2_rr_order", 32'(w), 32'(ord[i]));
      if (i == 4) req = '0;
      pulse_done($urandom_range(1, 6));
    end
    repeat (3) tick();

    // ptr=0, req 0101: 2 first, then 0; req[2] dropped mid-job
    do_reset();
    req = 4'b0001;
    wait_start(w);
    req = '0;
    pulse_done(2);
    repeat (2) tick();
    req = 4'b0101;
    wait_start(w);
    chk("t3_first", 32'(w), 32'd2);
    tick();
    req = 4'b0001;
    pulse_done(3);
    chk("t3_done2", 32'(done), 32'b0100);
    wait_start(w);
    chk("t3_second", 32'(w), 32'd0);
    req = '0;
    pulse_done(1);
    repeat (3) tick();

    // Watchdog expiry after 15 WAIT cycles
    req = 4'b0001;
    wait_start(w);
    req = '0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n++;
      if (done != '0) break;
    end
    chk("t4_to_latency", 32'(n), 32'd16);
    chk("t4_to_done", 32'(done), 32'b0001);
    chk("t4_err_set", 32'(err_timeout), 32'd1);
    repeat (3) tick();
    chk("t4_err_sticky", 32'(err_timeout), 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t4_err_clr", 32'(err_timeout), 32'd0);
    repeat (2) tick();

    // mm_done on the expiry edge counts as completion
    req = 4'b0001;
    wait_start(w);
    req = '0;
    pulse_done(15);
    chk("t4_late_done", 32'(done), 32'b0001);
    chk("t4_late_noerr", 32'(err_timeout), 32'd0);
    repeat (2) tick();

    // err_clr on the expiry edge: set wins
    req = 4'b0001;
    wait_start(w);
    req = '0;
    repeat (15) tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t4_set_wins", 32'(err_timeout), 32'd1);
    repeat (2) tick();

    // Async reset during WAIT
    req = 4'b0001;
    wait_start(w);
    req = '0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_outputs", 32'({grant, done, mm_start, mm_cfg, busy, err_timeout}), 32'd0);
    tick();
    rst_n = 1'b1;
    req = 4'b0010;
    wait_start(w);
    chk("t5_grant", 32'(grant), 32'b0010);
    chk("t5_start", 32'(mm_start), 32'd1);
    req = '0;
    pulse_done(2);
    repeat (3) tick();

    // Spurious mm_done in IDLE and ISSUE
    mm_done = 1'b1; tick(); mm_done = 1'b0;
    chk("t6_idle_done", 32'(done), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    req = 4'b0001;
    wait_start(w);
    req = '0;
    mm_done = 1'b1; tick(); mm_done = 1'b0;
    repeat (4) tick();
    chk("t6_issue_done", 32'(done), 32'd0);
    chk("t6_still_granted", 32'(grant), 32'b0001);
    pulse_done(1);
    chk("t6_real_done", 32'(done), 32'b0001);
    repeat (3) tick();

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      req     = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom());
      req_cfg = {$urandom(), $urandom()};
      mm_done = ($urandom_range(0, 5) == 0);
      err_clr = ($urandom_range(0, 19) == 0);
      tick();
    end
    req = '0; mm_done = 1'b0; err_clr = 1'b0;
    repeat (40) tick();

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
